// File: rtl/zbus_io_pkg.sv
// Shared constants, state/target types and port decoder for the ZXiznet Z80 I/O responder.
package zbus_io_pkg;

  localparam logic [7:0] PORT_RSTINT_HI = 8'h83;
  localparam logic [7:0] PORT_WCFG_HI   = 8'h82;
  localparam logic [7:0] PORT_SLCFG_HI  = 8'h81;
  localparam logic [7:0] PORT_SLADDR_HI = 8'h80;

  localparam int RI_EINT   = 6;
  localparam int RI_SLRST  = 5;
  localparam int RI_WRST   = 4;
  localparam int RI_ENA_SL = 3;
  localparam int RI_ENA_W  = 2;

  localparam int WC_WHI_MSB = 7;
  localparam int WC_WHI_LSB = 5;
  localparam int WC_PMODE   = 4;
  localparam int WC_A0INV   = 3;

  localparam int SC_MS = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_STB  = 3'd2,
    ST_HOLD = 3'd3,
    ST_WEND = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    T_NONE   = 3'd0,
    T_RSTINT = 3'd1,
    T_WCFG   = 3'd2,
    T_SLCFG  = 3'd3,
    T_SLADDR = 3'd4,
    T_DATA   = 3'd5
  } target_t;

  function automatic target_t decode_port(input logic [15:0] addr, input logic [7:0] lo);
    target_t t;
    t = T_NONE;
    if (addr[7:0] != lo) begin
      t = T_NONE;
    end else if (!addr[15]) begin
      t = T_DATA;
    end else begin
      case (addr[15:8])
        PORT_RSTINT_HI: t = T_RSTINT;
        PORT_WCFG_HI:   t = T_WCFG;
        PORT_SLCFG_HI:  t = T_SLCFG;
        PORT_SLADDR_HI: t = T_SLADDR;
        default:        t = T_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/zbus_io_sync.sv
// N-stage flop synchronizer with a per-bit reset value, used for bus strobes and interrupt inputs.
module zbus_io_sync #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stg [STAGES];

  // shift chain; stage 0 samples the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= RST_VAL;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[STAGES-1];

endmodule

// File: rtl/zbus_io_responder.sv
// Z80 I/O-bus target for the ZXiznet CPLD: control registers, W5300/SL811 strobe timing, zd read-back, zint.
// Build option ZBUS_IO_INTSYNC_EN: two-flop synchronizer on the interrupt inputs instead of a single capture flop.
module zbus_io_responder
  import zbus_io_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         STB_CYCLES  = 3,
  parameter logic [7:0] PORT_LO     = 8'hAB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic        ziorq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  output logic        ziorqge,
  output logic        zint_oe,
  input  logic [7:0]  bd_in,
  output logic [7:0]  bd_out,
  output logic        bd_oe,
  output logic        brd_n,
  output logic        bwr_n,
  output logic        w5300_cs_n,
  output logic [9:0]  w5300_addr,
  output logic        w5300_rst_n,
  input  logic        w5300_int_n,
  output logic        sl811_cs_n,
  output logic        sl811_a0,
  output logic        sl811_rst_n,
  output logic        sl811_ms_n,
  input  logic        sl811_intrq,
  input  logic        usb_power
);

`ifdef ZBUS_IO_INTSYNC_EN
  localparam int INT_STAGES = 2;
`else
  localparam int INT_STAGES = 1;
`endif
  localparam logic [2:0] STB_LAST = 3'(STB_CYCLES - 1);

  logic [2:0] w_bus_s;
  logic [2:0] w_in_s;
  logic       w_act;
  logic       w_bus_idle;
  logic [1:0] w_req;
  logic       w_int;
  logic [7:0] w_rstint_rd;
  target_t    w_tgt;
  logic       w_sel_w5300;
  logic [9:0] w_waddr;

  state_t      r_state;
  logic        r_act_d;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_rnw;
  logic [2:0]  r_cnt;
  logic [6:2]  r_rstint;
  logic [7:0]  r_wcfg;
  logic        r_ms;
  logic [7:0]  r_zd_out;
  logic        r_zd_oe;
  logic        r_zint_oe;
  logic [7:0]  r_bd_out;
  logic        r_bd_oe;
  logic        r_brd_n;
  logic        r_bwr_n;
  logic        r_w5300_cs_n;
  logic        r_sl811_cs_n;
  logic [9:0]  r_w5300_addr;
  logic        r_sl811_a0;

  zbus_io_sync #(.STAGES(SYNC_STAGES), .WIDTH(3), .RST_VAL(3'b111)) u_bus_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({ziorq_n, zrd_n, zwr_n}),
    .o_q   (w_bus_s)
  );

  zbus_io_sync #(.STAGES(INT_STAGES), .WIDTH(3), .RST_VAL(3'b001)) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({usb_power, sl811_intrq, w5300_int_n}),
    .o_q   (w_in_s)
  );

  assign w_act       = ~w_bus_s[2] & (~w_bus_s[1] | ~w_bus_s[0]);
  assign w_bus_idle  = &w_bus_s;
  assign w_req       = {w_in_s[1], ~w_in_s[0]};
  assign w_int       = |(w_req & r_rstint[RI_ENA_SL:RI_ENA_W]);
  assign w_rstint_rd = {w_int, r_rstint, w_req};
  assign w_tgt       = decode_port(r_addr, PORT_LO);
  assign w_sel_w5300 = (w_tgt == T_DATA) & r_wcfg[WC_PMODE];
  assign w_waddr     = {r_wcfg[WC_WHI_MSB:WC_WHI_LSB], r_addr[14:8]} ^ {9'd0, r_wcfg[WC_A0INV]};

  // access sequencer: decode, device strobe timing, read-back and register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_act_d      <= 1'b0;
      r_addr       <= 16'h0000;
      r_wdata      <= 8'h00;
      r_rnw        <= 1'b0;
      r_cnt        <= 3'd0;
      r_rstint     <= 5'b00000;
      r_wcfg       <= 8'h00;
      r_ms         <= 1'b0;
      r_zd_out     <= 8'h00;
      r_zd_oe      <= 1'b0;
      r_zint_oe    <= 1'b0;
      r_bd_out     <= 8'h00;
      r_bd_oe      <= 1'b0;
      r_brd_n      <= 1'b1;
      r_bwr_n      <= 1'b1;
      r_w5300_cs_n <= 1'b1;
      r_sl811_cs_n <= 1'b1;
      r_w5300_addr <= 10'h000;
      r_sl811_a0   <= 1'b0;
    end else begin
      r_act_d   <= w_act;
      r_zint_oe <= r_rstint[RI_EINT] & w_int;
      case (r_state)
        ST_IDLE: begin
          r_zd_oe <= 1'b0;
          if (w_act && !r_act_d) begin
            r_addr  <= za;
            r_wdata <= zd_in;
            r_rnw   <= ~w_bus_s[1];
            r_state <= ST_DEC;
          end
        end
        ST_DEC: begin
          case (w_tgt)
            T_NONE: r_state <= ST_WEND;
            T_SLADDR, T_DATA: begin
              r_w5300_cs_n <= ~w_sel_w5300;
              r_sl811_cs_n <= w_sel_w5300;
              if (w_sel_w5300) r_w5300_addr <= w_waddr;
              else             r_sl811_a0   <= (w_tgt == T_DATA);
              r_bd_out <= r_wdata;
              r_bd_oe  <= ~r_rnw;
              r_brd_n  <= ~r_rnw;
              r_bwr_n  <= r_rnw;
              r_cnt    <= STB_LAST;
              r_state  <= ST_STB;
            end
            T_RSTINT: begin
              if (r_rnw) r_zd_out <= w_rstint_rd;
              else       r_rstint <= r_wdata[6:2];
              r_state <= ST_HOLD;
            end
            T_WCFG: begin
              if (r_rnw) r_zd_out <= r_wcfg;
              else       r_wcfg   <= r_wdata;
              r_state <= ST_HOLD;
            end
            T_SLCFG: begin
              if (r_rnw) r_zd_out <= {6'd0, w_in_s[2], r_ms};
              else       r_ms     <= r_wdata[SC_MS];
              r_state <= ST_HOLD;
            end
            default: r_state <= ST_WEND;
          endcase
        end
        // the device access runs its full length even if the CPU lets go early
        ST_STB: begin
          if (r_cnt == 3'd0) begin
            if (r_rnw) r_zd_out <= bd_in;
            r_brd_n      <= 1'b1;
            r_bwr_n      <= 1'b1;
            r_bd_oe      <= 1'b0;
            r_w5300_cs_n <= 1'b1;
            r_sl811_cs_n <= 1'b1;
            r_state      <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_HOLD: begin
          r_zd_oe <= r_rnw & ~w_bus_s[1];
          r_state <= ST_WEND;
        end
        ST_WEND: begin
          r_zd_oe <= r_zd_oe & ~w_bus_s[1];
          if (w_bus_idle) begin
            r_zd_oe <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign zd_out      = r_zd_out;
  assign zd_oe       = r_zd_oe & ~zrd_n;
  assign ziorqge     = ~ziorq_n & (decode_port(za, PORT_LO) != T_NONE);
  assign zint_oe     = r_zint_oe;
  assign bd_out      = r_bd_out;
  assign bd_oe       = r_bd_oe;
  assign brd_n       = r_brd_n;
  assign bwr_n       = r_bwr_n;
  assign w5300_cs_n  = r_w5300_cs_n;
  assign w5300_addr  = r_w5300_addr;
  assign w5300_rst_n = r_rstint[RI_WRST];
  assign sl811_cs_n  = r_sl811_cs_n;
  assign sl811_a0    = r_sl811_a0;
  assign sl811_rst_n = r_rstint[RI_SLRST];
  assign sl811_ms_n  = ~r_ms;

endmodule

// File: tb/tb_zbus_io_responder.sv
// Scoreboard bench for zbus_io_responder: queued expectations for CPU read-back and device strobe cycles.
module tb_zbus_io_responder;

  localparam int STB = 3;

  typedef struct {
    logic       wr;
    logic       w5300;
    logic [9:0] addr;
    logic       a0;
    logic [7:0] data;
  } dev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] za = 16'h0000;
  logic [7:0]  zd_in = 8'h00;
  logic        ziorq_n = 1'b1, zrd_n = 1'b1, zwr_n = 1'b1;
  logic [7:0]  bd_in = 8'h00;
  logic        w5300_int_n = 1'b1, sl811_intrq = 1'b0, usb_power = 1'b0;
  logic [7:0]  zd_out, bd_out;
  logic        zd_oe, ziorqge, zint_oe, bd_oe, brd_n, bwr_n;
  logic        w5300_cs_n, w5300_rst_n, sl811_cs_n, sl811_a0, sl811_rst_n, sl811_ms_n;
  logic [9:0]  w5300_addr;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_rd[$];
  dev_t       q_dev[$];

  zbus_io_responder #(.SYNC_STAGES(2), .STB_CYCLES(STB), .PORT_LO(8'hAB)) dut (
    .clk(clk), .rst_n(rst_n), .za(za), .zd_in(zd_in), .zd_out(zd_out), .zd_oe(zd_oe),
    .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .ziorqge(ziorqge), .zint_oe(zint_oe),
    .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe), .brd_n(brd_n), .bwr_n(bwr_n),
    .w5300_cs_n(w5300_cs_n), .w5300_addr(w5300_addr), .w5300_rst_n(w5300_rst_n),
    .w5300_int_n(w5300_int_n), .sl811_cs_n(sl811_cs_n), .sl811_a0(sl811_a0),
    .sl811_rst_n(sl811_rst_n), .sl811_ms_n(sl811_ms_n), .sl811_intrq(sl811_intrq),
    .usb_power(usb_power)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic exp_ge(input logic [15:0] a);
    return (a[7:0] == 8'hAB) && (!a[15] || (a[15:8] >= 8'h80 && a[15:8] <= 8'h83));
  endfunction

  task automatic io(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    za = a; zd_in = d;
    @(posedge clk); #1;
    ziorq_n = 1'b0;
    if (rnw) zrd_n = 1'b0;
    else     zwr_n = 1'b0;
    #1 chk("ziorqge", {15'd0, ziorqge}, {15'd0, exp_ge(a)});
    repeat (hold) @(posedge clk);
    #1;
    ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic push_dev(input logic wr, input logic w5, input logic [9:0] ad,
                          input logic a0, input logic [7:0] d);
    dev_t e;
    e.wr = wr; e.w5300 = w5; e.addr = ad; e.a0 = a0; e.data = d;
    q_dev.push_back(e);
  endtask

  // read-back monitor: each zd_oe assertion consumes one expected byte
  logic zd_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (zd_oe && !zd_oe_prev) begin
      checks++;
      if (q_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %0h exp none", zd_out);
      end else begin
        logic [7:0] e;
        e = q_rd.pop_front();
        if (zd_out !== e) begin
          errors++;
          $display("FAIL rd_data got %0h exp %0h", zd_out, e);
        end
      end
    end
    zd_oe_prev = zd_oe;
  end

  // device monitor: records a strobe pulse and compares it when it ends
  int m_len = 0;
  logic m_wr, m_w5, m_sl, m_a0, m_oe;
  logic [9:0] m_addr;
  logic [7:0] m_data;
  always @(negedge clk) begin
    if (!brd_n || !bwr_n) begin
      if (m_len == 0) begin
        m_wr = !bwr_n; m_w5 = !w5300_cs_n; m_sl = !sl811_cs_n;
        m_addr = w5300_addr; m_a0 = sl811_a0; m_data = bd_out; m_oe = bd_oe;
      end
      m_len++;
    end else if (m_len > 0) begin
      if (rst_n) begin
        checks++;
        if (q_dev.size() == 0) begin
          errors++;
          $display("FAIL dev_unexpected got wr=%0b len=%0d exp none", m_wr, m_len);
        end else begin
          dev_t e;
          e = q_dev.pop_front();
          if (m_wr !== e.wr || m_w5 !== e.w5300 || m_sl !== !e.w5300 ||
              (e.w5300 && m_addr !== e.addr) || (!e.w5300 && m_a0 !== e.a0) ||
              (e.wr && (m_data !== e.data || m_oe !== 1'b1)) || (!e.wr && m_oe !== 1'b0) ||
              m_len != STB) begin
            errors++;
            $display("FAIL dev_cycle got wr=%0b w5=%0b sl=%0b addr=%0h a0=%0b d=%0h oe=%0b len=%0d exp wr=%0b w5=%0b addr=%0h a0=%0b d=%0h len=%0d",
                     m_wr, m_w5, m_sl, m_addr, m_a0, m_data, m_oe, m_len,
                     e.wr, e.w5300, e.addr, e.a0, e.data, STB);
          end
        end
      end
      m_len = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_zd_oe", {15'd0, zd_oe}, 16'd0);
    chk("rst_bd_oe", {15'd0, bd_oe}, 16'd0);
    chk("rst_zint_oe", {15'd0, zint_oe}, 16'd0);
    chk("rst_strobes", {12'd0, brd_n, bwr_n, w5300_cs_n, sl811_cs_n}, 16'hF);
    chk("rst_dev_rst", {14'd0, w5300_rst_n, sl811_rst_n}, 16'd0);
    chk("rst_ms_n", {15'd0, sl811_ms_n}, 16'd1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    q_rd.push_back(8'h00);
    io(16'h83AB, 1'b1, 8'h00, 12);

    io(16'h83AB, 1'b0, 8'h30, 12);
    chk("w5300_rst_n_set", {15'd0, w5300_rst_n}, 16'd1);
    chk("sl811_rst_n_set", {15'd0, sl811_rst_n}, 16'd1);
    q_rd.push_back(8'h30);
    io(16'h83AB, 1'b1, 8'h00, 12);

    io(16'h82AB, 1'b0, 8'hB8, 12);
    q_rd.push_back(8'hB8);
    io(16'h82AB, 1'b1, 8'h00, 12);
    push_dev(1'b1, 1'b1, 10'h2AA, 1'b0, 8'h5A);
    io(16'h2BAB, 1'b0, 8'h5A, 12);

    io(16'h82AB, 1'b0, 8'h00, 12);
    bd_in = 8'hC3;
    push_dev(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    q_rd.push_back(8'hC3);
    io(16'h2BAB, 1'b1, 8'h00, 12);

    push_dev(1'b1, 1'b0, 10'h000, 1'b0, 8'h12);
    io(16'h80AB, 1'b0, 8'h12, 12);

    io(16'h83AC, 1'b1, 8'h00, 12);
    io(16'h84AB, 1'b0, 8'h77, 12);

    usb_power = 1'b1;
    io(16'h81AB, 1'b0, 8'hFF, 12);
    chk("sl811_ms_n_set", {15'd0, sl811_ms_n}, 16'd0);
    q_rd.push_back(8'h03);
    io(16'h81AB, 1'b1, 8'h00, 12);

    w5300_int_n = 1'b0;
    io(16'h83AB, 1'b0, 8'h44, 12);
    q_rd.push_back(8'hC5);
    io(16'h83AB, 1'b1, 8'h00, 12);
    chk("zint_oe_on", {15'd0, zint_oe}, 16'd1);
    w5300_int_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("zint_oe_off", {15'd0, zint_oe}, 16'd0);
    q_rd.push_back(8'h44);
    io(16'h83AB, 1'b1, 8'h00, 12);
    io(16'h83AB, 1'b0, 8'hC7, 12);
    q_rd.push_back(8'h44);
    io(16'h83AB, 1'b1, 8'h00, 12);

    bd_in = 8'h99;
    push_dev(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    io(16'h2BAB, 1'b1, 8'h00, 4);

    @(posedge clk); #1;
    za = 16'h2BAB; zd_in = 8'h77;
    @(posedge clk); #1;
    ziorq_n = 1'b0; zwr_n = 1'b0;
    n = 0;
    while (bwr_n && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bwr_seen", {15'd0, bwr_n}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {13'd0, bwr_n, sl811_cs_n, w5300_cs_n}, 16'h7);
    chk("abort_bd_oe", {15'd0, bd_oe}, 16'd0);
    chk("abort_rst_outs", {13'd0, w5300_rst_n, sl811_rst_n, sl811_ms_n}, 16'h1);
    @(posedge clk); #1;
    ziorq_n = 1'b1; zwr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    q_rd.push_back(8'h00);
    io(16'h83AB, 1'b1, 8'h00, 12);
    q_rd.push_back(8'h00);
    io(16'h82AB, 1'b1, 8'h00, 12);
    chk("post_rst_zint", {15'd0, zint_oe}, 16'd0);

    repeat (10) @(posedge clk);
    chk("rd_queue_empty", 16'(q_rd.size()), 16'd0);
    chk("dev_queue_empty", 16'(q_dev.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
